// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int REQ_CYCLES     = 50,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_CYCLES  = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       start,
    input  logic [7:0] data_in,
    input  logic       psClk,
    input  logic       psData,
    output logic       clk_oe,
    output logic       dat_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err
);

    localparam int             FW        = $clog2(FILTER_CYCLES + 1);
    localparam logic [FW-1:0]  FILT_LAST = FW'(FILTER_CYCLES - 1);
    localparam logic [19:0]    INH_LAST  = 20'(INHIBIT_CYCLES - 1);
    localparam logic [19:0]    REQ_LAST  = 20'(REQ_CYCLES - 1);
    localparam logic [19:0]    TMO_LAST  = 20'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        WAIT_IDLE,
        DONE
    } state_t;

    state_t state, state_next;

    // Index 0 carries the clock line, index 1 the data line.
    logic [1:0]    raw;
    logic [1:0]    sync1, sync2, filt;
    logic [FW-1:0] fcnt [2];
    logic          fall_clk;

    logic [19:0]   phase_cnt;
    logic [19:0]   tmo_cnt;
    logic [7:0]    data_q;
    logic          par_q;
    logic          nack_q;
    logic          dat_q;
    logic [3:0]    bit_n;
    logic          tmo_hit;
    logic          tmo_fire;
    logic          tmo_active;

    assign raw = {psData, psClk};

    // Two-flop synchronizers for the asynchronous pad levels (idle high).
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Stability filter: a level change is taken only after FILTER_CYCLES equal samples;
    // fall_clk strobes on the same edge the filtered clock drops.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            filt     <= 2'b11;
            fcnt[0]  <= '0;
            fcnt[1]  <= '0;
            fall_clk <= 1'b0;
        end else begin
            fall_clk <= filt[0] & ~sync2[0] & (fcnt[0] == FILT_LAST);
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FILT_LAST) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + FW'(1);
                end
            end
        end
    end

    assign tmo_active = (state == SEND) || (state == ACK) || (state == WAIT_IDLE);
    assign tmo_hit    = tmo_active && (tmo_cnt == TMO_LAST);

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a real clock edge wins over a timeout landing in the same cycle.
    always_comb begin
        state_next = state;
        tmo_fire   = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = INHIBIT;
            end
            INHIBIT: begin
                if (phase_cnt == INH_LAST) state_next = REQ;
            end
            REQ: begin
                if (phase_cnt == REQ_LAST) state_next = SEND;
            end
            SEND: begin
                if (fall_clk) begin
                    if (bit_n == 4'd9) state_next = ACK;
                end else if (tmo_hit) begin
                    state_next = DONE;
                    tmo_fire   = 1'b1;
                end
            end
            ACK: begin
                if (fall_clk) begin
                    state_next = WAIT_IDLE;
                end else if (tmo_hit) begin
                    state_next = DONE;
                    tmo_fire   = 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (filt == 2'b11) begin
                    state_next = DONE;
                end else if (tmo_hit) begin
                    state_next = DONE;
                    tmo_fire   = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: phase/timeout counters, latched byte, bit shifter and ack result.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            phase_cnt <= '0;
            tmo_cnt   <= '0;
            data_q    <= '0;
            par_q     <= 1'b0;
            nack_q    <= 1'b0;
            dat_q     <= 1'b0;
            bit_n     <= '0;
        end else begin
            if ((state_next != state) || !((state == INHIBIT) || (state == REQ))) begin
                phase_cnt <= '0;
            end else begin
                phase_cnt <= phase_cnt + 20'd1;
            end

            if ((state_next != state) || fall_clk || !tmo_active) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt != 20'hFFFFF) begin
                tmo_cnt <= tmo_cnt + 20'd1;
            end

            if ((state == IDLE) && start) begin
                data_q <= data_in;
                par_q  <= ~^data_in;
                nack_q <= 1'b0;
            end

            // Start bit stays driven after the clock is released until the first device edge.
            if ((state == REQ) && (state_next == SEND)) begin
                bit_n <= '0;
                dat_q <= 1'b1;
            end

            if ((state == SEND) && fall_clk) begin
                bit_n <= bit_n + 4'd1;
                if (bit_n < 4'd8) begin
                    dat_q <= ~data_q[bit_n[2:0]];
                end else if (bit_n == 4'd8) begin
                    dat_q <= ~par_q;
                end else begin
                    dat_q <= 1'b0;
                end
            end

            if ((state == ACK) && fall_clk) begin
                nack_q <= filt[1];
            end

            if (tmo_fire) begin
                nack_q <= 1'b1;
                dat_q  <= 1'b0;
            end
        end
    end

    assign clk_oe  = (state == INHIBIT) || (state == REQ);
    assign dat_oe  = (state == REQ) || ((state == SEND) && dat_q);
    assign busy    = (state != IDLE) && (state != DONE);
    assign done    = (state == DONE);
    assign ack_err = (state == DONE) && nack_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;

    localparam int INH   = 50;
    localparam int REQN  = 10;
    localparam int TMO   = 2000;
    localparam int FILT  = 4;
    // pad fall -> 2 sync + FILT filter -> strobe consumed one edge later, then TMO cycles
    localparam int TO_LAT = 2 + FILT + 1 + TMO;

    logic       Clk;
    logic       Reset;
    logic       start;
    logic [7:0] data_in;
    logic       ps_clk;
    logic       ps_dat;
    logic       clk_oe;
    logic       dat_oe;
    logic       busy;
    logic       done;
    logic       ack_err;

    logic       dev_clk;
    logic       dev_dat;

    assign ps_clk = dev_clk & ~clk_oe;
    assign ps_dat = dev_dat & ~dat_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .REQ_CYCLES(REQN),
        .TIMEOUT_CYCLES(TMO),
        .FILTER_CYCLES(FILT)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .start(start),
        .data_in(data_in),
        .psClk(ps_clk),
        .psData(ps_dat),
        .clk_oe(clk_oe),
        .dat_oe(dat_oe),
        .busy(busy),
        .done(done),
        .ack_err(ack_err)
    );

    typedef struct {
        logic [7:0] d;
        logic       par;
        logic       aerr;
        bit         chk_frame;
        bit         chk_tmo;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int fall_idx = 0;
    int mode = 0;
    int inh_cnt = 0;
    int req_cnt = 0;
    logic [10:0] cap;
    logic model_busy;
    logic busy_prev;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT reports done.
    always @(negedge Clk) begin
        if (Reset) begin
            inh_cnt = 0;
            req_cnt = 0;
        end else begin
            if (clk_oe && !dat_oe) inh_cnt++;
            if (clk_oe && dat_oe) req_cnt++;
        end
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("ack_err", ack_err, mon_e.aerr);
                check("busy_at_done", busy, 1'b0);
                check("busy_before_done", busy_prev, 1'b1);
                check("clk_oe_at_done", clk_oe, 1'b0);
                check("dat_oe_at_done", dat_oe, 1'b0);
                check("inhibit_len", inh_cnt, INH);
                check("request_len", req_cnt, REQN);
                if (mon_e.chk_frame)
                    check("frame", cap, {1'b1, mon_e.par, mon_e.d, 1'b0});
                if (mon_e.chk_tmo)
                    check("timeout_latency", cyc - fall_cyc, TO_LAT);
            end
            inh_cnt = 0;
            req_cnt = 0;
        end
        busy_prev = busy;
    end

    // Device model: 40-cycle clock, samples on rising edges, acks on the 11th clock.
    initial begin
        bit seen;
        int md;
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        model_busy = 1'b0;
        cap = '0;
        forever begin
            seen = 1'b0;
            forever begin
                @(negedge Clk);
                if (clk_oe) seen = 1'b1;
                else if (seen && ps_dat === 1'b0) break;
            end
            model_busy = 1'b1;
            md = mode;
            cap = '0;
            fall_idx = 0;
            repeat (10) @(negedge Clk);
            cap[0] = ps_dat;
            for (int k = 1; k <= 10; k++) begin
                dev_clk = 1'b0;
                fall_idx = k;
                fall_cyc = cyc;
                if (md == 2 && k == 4) begin
                    for (int w = 0; w < 3000 && !done; w++) @(negedge Clk);
                    break;
                end
                repeat (20) @(negedge Clk);
                dev_clk = 1'b1;
                cap[k] = ps_dat;
                repeat (20) @(negedge Clk);
            end
            if (md != 2) begin
                if (md == 0) dev_dat = 1'b0;
                repeat (10) @(negedge Clk);
                dev_clk = 1'b0;
                fall_idx = 11;
                repeat (20) @(negedge Clk);
                dev_clk = 1'b1;
                repeat (10) @(negedge Clk);
                dev_dat = 1'b1;
            end
            dev_clk = 1'b1;
            model_busy = 1'b0;
        end
    end

    task automatic issue(input logic [7:0] d, input logic par, input logic aerr,
                         input int md, input bit fchk, input bit tchk, input bit push);
        exp_t e;
        if (push) begin
            e.d = d;
            e.par = par;
            e.aerr = aerr;
            e.chk_frame = fchk;
            e.chk_tmo = tchk;
            sb.push_back(e);
        end
        mode = md;
        data_in = d;
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int w = 0; w < 6000; w++) begin
            @(negedge Clk);
            if (done) break;
        end
        check(name, done, 1'b1);
    endtask

    task automatic wait_model_idle();
        for (int w = 0; w < 3000; w++) begin
            if (!model_busy) break;
            @(negedge Clk);
        end
        check("model_idle", model_busy, 1'b0);
        repeat (5) @(negedge Clk);
    endtask

    task automatic wait_fall(input int k);
        for (int w = 0; w < 3000; w++) begin
            @(negedge Clk);
            if (model_busy && fall_idx == k) break;
        end
        check("reach_fall", fall_idx, k);
    endtask

    initial begin
        repeat (60000) @(posedge Clk);
        $display("FAIL watchdog: simulation exceeded 60000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        start = 1'b0;
        data_in = 8'h00;
        repeat (3) @(negedge Clk);
        check("rst_clk_oe", clk_oe, 1'b0);
        check("rst_dat_oe", dat_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ack_err", ack_err, 1'b0);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);

        // 0xED: parity 1, ack
        issue(8'hED, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1);
        wait_done("done_ed");
        wait_model_idle();

        // 0x01: parity 0, ack
        issue(8'h01, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1);
        wait_done("done_01");
        wait_model_idle();

        // 0xFF: parity 1, device NACKs
        issue(8'hFF, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b1);
        wait_done("done_nack");
        wait_model_idle();

        // 0x01 with device stalling after 4th fall: timeout
        issue(8'h01, 1'b0, 1'b1, 2, 1'b0, 1'b1, 1'b1);
        wait_fall(4);
        repeat (10) @(negedge Clk);
        check("dat_oe_during_stall", dat_oe, 1'b1);
        wait_done("done_timeout");
        wait_model_idle();

        // 0xED with a 0xFF start mid-transfer (ignored), then start right after done
        issue(8'hED, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1);
        wait_fall(5);
        data_in = 8'hFF;
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        check("busy_mid_start", busy, 1'b1);
        wait_done("done_ed_mid");
        @(negedge Clk);
        issue(8'h01, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1);
        check("busy_after_back2back", busy, 1'b1);
        wait_done("done_back2back");
        wait_model_idle();

        // Reset during SEND: lines released, no done
        issue(8'h01, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        wait_fall(3);
        repeat (10) @(negedge Clk);
        check("dat_oe_before_reset", dat_oe, 1'b1);
        Reset = 1'b1;
        @(negedge Clk);
        check("mid_rst_clk_oe", clk_oe, 1'b0);
        check("mid_rst_dat_oe", dat_oe, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        Reset = 1'b0;
        wait_model_idle();

        // 0xF4 after reset: parity 0, ack
        issue(8'hF4, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1);
        wait_done("done_f4");
        wait_model_idle();

        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
